imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 156 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RISC-V immediate decoder feeding a small FIFO of decoded
// immediates. Each accepted instruction word is decoded combinationally and
// the (immediate, format) pair is stored at the tail; the head is presented
// on imm_gen_out / imm_gen_fmt with a valid/ready handshake.
//
// Optional feature: define IMM_GEN_ZICSR_EN to decode the CSR-immediate
// forms (opcode 1110011 with funct3[2]=1) as format Z (code 6), carrying the
// zero-extended uimm field in[19:15]. Without the macro those words decode
// as ordinary I-type and code 6 never appears.

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     imm_gen_flush,
  input  logic                     imm_gen_in_valid,
  input  logic [31:0]              imm_gen_in,
  output logic                     imm_gen_in_ready,
  output logic                     imm_gen_out_valid,
  input  logic                     imm_gen_out_ready,
  output logic [XLEN-1:0]          imm_gen_out,
  output logic [2:0]               imm_gen_fmt,
  output logic [$clog2(DEPTH):0]   imm_gen_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  fmt_e              fmt_dec;
  logic [31:0]       imm32;
  logic [XLEN-1:0]   imm_ext;

  logic [XLEN-1:0]   imm_mem [DEPTH];
  logic [2:0]        fmt_mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              push;
  logic              pop;

  // Decode the incoming word into a format code and a 32-bit immediate.
  always_comb begin
    fmt_dec = FMT_ILL;
    imm32   = '0;
    case (imm_gen_in[6:0])
      7'b0110111, 7'b0010111: begin
        fmt_dec = FMT_U;
        imm32   = {imm_gen_in[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt_dec = FMT_J;
        imm32   = {{11{imm_gen_in[31]}}, imm_gen_in[31], imm_gen_in[19:12],
                   imm_gen_in[20], imm_gen_in[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: begin
        fmt_dec = FMT_I;
        imm32   = {{20{imm_gen_in[31]}}, imm_gen_in[31:20]};
      end
      7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
        if (imm_gen_in[14]) begin
          fmt_dec = FMT_Z;
          imm32   = {27'b0, imm_gen_in[19:15]};
        end else begin
          fmt_dec = FMT_I;
          imm32   = {{20{imm_gen_in[31]}}, imm_gen_in[31:20]};
        end
`else
        fmt_dec = FMT_I;
        imm32   = {{20{imm_gen_in[31]}}, imm_gen_in[31:20]};
`endif
      end
      7'b0100011: begin
        fmt_dec = FMT_S;
        imm32   = {{20{imm_gen_in[31]}}, imm_gen_in[31:25], imm_gen_in[11:7]};
      end
      7'b1100011: begin
        fmt_dec = FMT_B;
        imm32   = {{19{imm_gen_in[31]}}, imm_gen_in[31], imm_gen_in[7],
                   imm_gen_in[30:25], imm_gen_in[11:8], 1'b0};
      end
      7'b0110011: begin
        fmt_dec = FMT_R;
        imm32   = '0;
      end
      default: begin
        fmt_dec = FMT_ILL;
        imm32   = '0;
      end
    endcase
  end

  // Widen to XLEN; every 32-bit immediate above is already sign-correct in
  // bit 31, so replicating bit 31 covers both signed and zero-extended cases.
  generate
    if (XLEN > 32) begin : g_wide
      assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_narrow
      assign imm_ext = imm32;
    end
  endgenerate

  assign imm_gen_in_ready  = (count < DEPTH_C);
  assign imm_gen_out_valid = (count != '0);
  assign push              = imm_gen_in_valid & imm_gen_in_ready;
  assign pop               = imm_gen_out_valid & imm_gen_out_ready;

  // Pointer and occupancy bookkeeping; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (imm_gen_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only observable through a valid head entry,
  // so it needs no reset.
  always_ff @(posedge clk) begin
    if (push && !imm_gen_flush) begin
      imm_mem[wr_ptr] <= imm_ext;
      fmt_mem[wr_ptr] <= fmt_dec;
    end
  end

  assign imm_gen_out   = imm_gen_out_valid ? imm_mem[rd_ptr] : '0;
  assign imm_gen_fmt   = imm_gen_out_valid ? fmt_mem[rd_ptr] : 3'd0;
  assign imm_gen_count = count;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe against a
// queue-based reference model that decodes immediates with plain integer
// arithmetic. Honors IMM_GEN_ZICSR_EN the same way as the design.

module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic              imm_gen_flush;
  logic              imm_gen_in_valid;
  logic [31:0]       imm_gen_in;
  logic              imm_gen_in_ready;
  logic              imm_gen_out_valid;
  logic              imm_gen_out_ready;
  logic [XLEN-1:0]   imm_gen_out;
  logic [2:0]        imm_gen_fmt;
  logic [CW-1:0]     imm_gen_count;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [31:0]       model_q [$];

  imm_gen_pipe #(.XLEN(XLEN), .DEPTH(DEPTH)) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imm_gen_flush     (imm_gen_flush),
    .imm_gen_in_valid  (imm_gen_in_valid),
    .imm_gen_in        (imm_gen_in),
    .imm_gen_in_ready  (imm_gen_in_ready),
    .imm_gen_out_valid (imm_gen_out_valid),
    .imm_gen_out_ready (imm_gen_out_ready),
    .imm_gen_out       (imm_gen_out),
    .imm_gen_fmt       (imm_gen_fmt),
    .imm_gen_count     (imm_gen_count)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference format classification straight from the opcode table.
  function automatic logic [2:0] ref_fmt(input logic [31:0] w);
    case (w[6:0])
      7'b0110111, 7'b0010111: return 3'd4;
      7'b1101111:             return 3'd5;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: return 3'd1;
      7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
        if (w[14]) return 3'd6;
`endif
        return 3'd1;
      end
      7'b0100011: return 3'd2;
      7'b1100011: return 3'd3;
      7'b0110011: return 3'd0;
      default:    return 3'd7;
    endcase
  endfunction

  // Reference immediate built from signed integer shifts of the word.
  function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] w);
    int     sw;
    int     a, b, c, d;
    longint r;
    sw = int'(w);
    r  = 0;
    case (ref_fmt(w))
      3'd1: r = longint'(sw >>> 20);
      3'd2: begin
        a = (sw >>> 25) <<< 5;
        b = int'((w >> 7) & 32'h1f);
        r = longint'(a | b);
      end
      3'd3: begin
        a = (sw >>> 31) <<< 12;
        b = int'((w >> 7) & 32'h1) <<< 11;
        c = int'((w >> 25) & 32'h3f) <<< 5;
        d = int'((w >> 8) & 32'hf) <<< 1;
        r = longint'(a | b | c | d);
      end
      3'd4: r = longint'(int'(w & 32'hFFFF_F000));
      3'd5: begin
        a = (sw >>> 31) <<< 20;
        b = int'((w >> 12) & 32'hff) <<< 12;
        c = int'((w >> 20) & 32'h1) <<< 11;
        d = int'((w >> 21) & 32'h3ff) <<< 1;
        r = longint'(a | b | c | d);
      end
      3'd6: r = longint'(int'((w >> 15) & 32'h1f));
      default: r = 0;
    endcase
    return XLEN'(r);
  endfunction

  // One comparison: count it, and report on mismatch.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model's view of the buffer.
  task automatic check_output();
    logic [63:0] exp_imm;
    logic [63:0] exp_fmt;
    exp_imm = '0;
    exp_fmt = '0;
    if (model_q.size() != 0) begin
      exp_imm = 64'(ref_imm(model_q[0]));
      exp_fmt = 64'(ref_fmt(model_q[0]));
    end
    check("count",     64'(imm_gen_count),     64'(model_q.size()));
    check("out_valid", 64'(imm_gen_out_valid), 64'(model_q.size() != 0));
    check("in_ready",  64'(imm_gen_in_ready),  64'(model_q.size() < DEPTH));
    check("head_imm",  64'(imm_gen_out),       exp_imm);
    check("head_fmt",  64'(imm_gen_fmt),       exp_fmt);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic apply_stimulus(input logic v, input logic [31:0] w,
                                input logic r, input logic f);
    logic m_push, m_pop;
    imm_gen_in_valid  = v;
    imm_gen_in        = w;
    imm_gen_out_ready = r;
    imm_gen_flush     = f;
    m_push = v && (model_q.size() < DEPTH);
    m_pop  = r && (model_q.size() != 0);
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else begin
      if (m_pop)  void'(model_q.pop_front());
      if (m_push) model_q.push_back(w);
    end
    #1;
    check_output();
  endtask

  logic [6:0]      ops [10];
  logic [31:0]     rw;
  logic [XLEN-1:0] all_ones;

  // Directed scenarios followed by a randomized soak.
  initial begin
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011,
            7'b0010011, 7'b0001111, 7'b1110011, 7'b0100011, 7'b1100011};
    all_ones          = '1;
    rst_n             = 1'b0;
    imm_gen_flush     = 1'b0;
    imm_gen_in_valid  = 1'b0;
    imm_gen_in        = '0;
    imm_gen_out_ready = 1'b0;

    // Reset values are visible before any clock edge.
    #2;
    check_output();
    check("rst_in_ready", 64'(imm_gen_in_ready), 64'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // addi x1,x0,-1 on the first edge after reset release.
    apply_stimulus(1'b1, 32'hFFF0_0093, 1'b0, 1'b0);
    check("addi_valid", 64'(imm_gen_out_valid), 64'd1);
    check("addi_fmt",   64'(imm_gen_fmt), 64'd1);
    check("addi_imm",   64'(imm_gen_out), 64'(all_ones));
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Branch and jump encodings with strongly negative offsets.
    apply_stimulus(1'b1, 32'h8000_0EE3, 1'b0, 1'b0);
    check("b_fmt", 64'(imm_gen_fmt), 64'd3);
    check("b_imm", 64'(imm_gen_out), 64'(XLEN'(64'hFFFF_FFFF_FFFF_F81C)));
    apply_stimulus(1'b1, 32'h8000_00EF, 1'b1, 1'b0);
    check("jal_fmt", 64'(imm_gen_fmt), 64'd5);
    check("jal_imm", 64'(imm_gen_out), 64'(XLEN'(64'hFFFF_FFFF_FFF0_0000)));
    // 0x80000063 encodes the -4096 branch offset exactly.
    apply_stimulus(1'b1, 32'h8000_0063, 1'b1, 1'b0);
    check("bmax_imm", 64'(imm_gen_out), 64'(XLEN'(64'hFFFF_FFFF_FFFF_F000)));
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill past capacity with the consumer stalled, then drain in order.
    for (int i = 0; i <= DEPTH; i++) begin
      apply_stimulus(1'b1, 32'h0010_0013 + (32'(i) << 20), 1'b0, 1'b0);
      if (i == DEPTH - 1) begin
        check("full_in_ready", 64'(imm_gen_in_ready), 64'd0);
        check("full_count",    64'(imm_gen_count),    64'(DEPTH));
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
      check("drain_count", 64'(imm_gen_count), 64'(DEPTH - 1 - i));
    end

    // Steady push+pop across several pointer wraps.
    apply_stimulus(1'b1, 32'h1234_5037, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      rw = $urandom;
      rw[6:0] = ops[i % 10];
      apply_stimulus(1'b1, rw, 1'b1, 1'b0);
      check("stream_count", 64'(imm_gen_count), 64'd1);
    end
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with a full buffer and a push pending drops everything.
    apply_stimulus(1'b1, 32'hABCD_E0B7, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h0040_0113, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h0050_0193, 1'b1, 1'b1);
    check("flush_count", 64'(imm_gen_count),     64'd0);
    check("flush_valid", 64'(imm_gen_out_valid), 64'd0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-stream clears outputs without a clock.
    apply_stimulus(1'b1, 32'hFFF0_0093, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check_output();
    check("arst_out", 64'(imm_gen_out), 64'd0);
    rst_n = 1'b1;
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // CSR immediate form.
    apply_stimulus(1'b1, 32'h0002_D073, 1'b0, 1'b0);
`ifdef IMM_GEN_ZICSR_EN
    check("csrwi_fmt", 64'(imm_gen_fmt), 64'd6);
    check("csrwi_imm", 64'(imm_gen_out), 64'd5);
`else
    check("csrwi_fmt", 64'(imm_gen_fmt), 64'd1);
    check("csrwi_imm", 64'(imm_gen_out), 64'd0);
`endif
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      rw = $urandom;
      if ($urandom_range(0, 4) != 0) rw[6:0] = ops[$urandom_range(0, 9)];
      apply_stimulus($urandom_range(0, 3) != 0, rw,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
